// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word-aligned requests to
// instruction memory under a credit limit, buffers in-order responses in a
// small FIFO and presents them, tagged with their PC, to the core.
// A redirect flushes the FIFO and marks every in-flight request for discard.
module instruction_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_Redirect_Addr,
  output logic            o_Mem_Req_Valid,
  output logic [XLEN-1:0] o_Mem_Req_Addr,
  input  logic            i_Mem_Req_Ready,
  input  logic            i_Mem_Resp_Valid,
  input  logic [XLEN-1:0] i_Mem_Resp_Data,
  output logic            o_Instr_Valid,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_Instr_Addr,
  input  logic            i_Instr_Ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc   [FIFO_DEPTH];

  logic             credit_ok;
  logic             req_fire;
  logic             resp_accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] outstanding_next;
  logic [XLEN-1:0]  redirect_pc;

  // Handshake decode, credit check and the per-cycle outstanding count.
  // Outstanding includes requests already marked for discard, so the sum with
  // the FIFO occupancy bounds every response that can still land in the FIFO.
  always_comb begin
    redirect_pc      = {i_Redirect_Addr[XLEN-1:2], 2'b00};
    credit_ok        = ({1'b0, outstanding} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
    o_Mem_Req_Valid  = credit_ok && !i_Redirect && !i_Reset;
    o_Mem_Req_Addr   = fetch_pc;
    req_fire         = o_Mem_Req_Valid && i_Mem_Req_Ready;
    resp_accept      = i_Mem_Resp_Valid && (outstanding != '0);
    push             = resp_accept && (discard == '0);
    o_Instr_Valid    = (fifo_count != '0);
    pop              = o_Instr_Valid && i_Instr_Ready;
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(resp_accept);
    o_Instruction    = o_Instr_Valid ? fifo_data[rd_ptr] : '0;
    o_Instr_Addr     = o_Instr_Valid ? fifo_pc[rd_ptr]   : '0;
  end

  // PCs, request/discard accounting and FIFO pointers; redirect takes priority
  // and turns whatever is still in flight after this cycle into discards.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (i_Redirect) begin
        fetch_pc   <= redirect_pc;
        resp_pc    <= redirect_pc;
        discard    <= outstanding_next;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (resp_accept && (discard != '0)) begin
          discard <= discard - CNT_W'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + XLEN'(4);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge i_Clock) begin
    if (push && !i_Redirect) begin
      fifo_data[wr_ptr] <= i_Mem_Resp_Data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the cpu core. Owns the fetch PC and issues word-aligned requests to instruction memory over a valid/ready request channel. It buffers in-order responses in a small FIFO and hands instructions, each tagged with its PC, to the core over a valid/ready channel. A redirect from the core (branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new address.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
i_Clock  input  1  clock, rising edge
i_Reset  input  1  asynchronous, active-high reset
i_Redirect  input  1  core requests fetch restart
i_Redirect_Addr  input  XLEN  restart address; bits [1:0] ignored (treated as 0)
o_Mem_Req_Valid  output  1  fetch request valid
o_Mem_Req_Addr  output  XLEN  fetch address, word aligned
i_Mem_Req_Ready  input  1  memory accepts request
i_Mem_Resp_Valid  input  1  response data valid; in order; no backpressure
i_Mem_Resp_Data  input  XLEN  instruction word
o_Instr_Valid  output  1  instruction available to core
o_Instruction  output  XLEN  FIFO head instruction
o_Instr_Addr  output  XLEN  PC of o_Instruction
i_Instr_Ready  input  1  core consumes head

Behaviour:
- Reset values (async, immediate): fetch PC = RESET_PC, response PC = RESET_PC, outstanding = 0, discard = 0, FIFO empty. o_Instr_Valid = 0, o_Instruction = 0, o_Instr_Addr = 0, o_Mem_Req_Addr = RESET_PC, o_Mem_Req_Valid = 0 while reset is asserted.
- Credit rule: o_Mem_Req_Valid = (outstanding + fifo_count < FIFO_DEPTH) && !i_Redirect. Outstanding includes to-be-discarded requests. The FIFO can never overflow.
- o_Mem_Req_Addr = fetch PC register. Handshake (valid & ready): fetch PC += 4 (wraps mod 2^XLEN), outstanding += 1.
- Response on i_Mem_Resp_Valid: outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise: write {data, response PC} into the FIFO, response PC += 4.
  - A response with outstanding == 0 is illegal and ignored.
- Output: o_Instr_Valid = (fifo_count != 0). o_Instruction and o_Instr_Addr show the head entry. Pop on valid & ready.
- Latency: the response is written at the clock edge where i_Mem_Resp_Valid is high. o_Instr_Valid rises in the following cycle; there is no same-cycle bypass. After reset release, o_Mem_Req_Valid is high in the first cycle.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Redirect (one-cycle pulse, evaluated at the clock edge):
  - FIFO flushed (count = 0).
  - fetch PC and response PC load {i_Redirect_Addr[XLEN-1:2], 2'b00}.
  - discard = outstanding after this cycle's accounting (a same-cycle response consumes one old request first).
  - A pop in the redirect cycle counts as delivered.
  - No request handshake occurs in the redirect cycle (valid forced low). An un-accepted request may be withdrawn or readdressed on redirect; the memory interface permits this.
- Back-to-back redirects: the later redirect wins. discard accumulates all older in-flight requests.
- While discard > 0, new requests may still issue within credit. Their responses arrive after the discarded ones, in order.
- Reset mid-operation: all counters cleared. In-flight memory responses arriving after reset release are illegal; the memory is reset together with this block.

Test Plan:
- Reset release, memory ready=1, 1-cycle response latency, core ready=1 -> requests 0x0, 0x4, 0x8 on consecutive-capable cycles; core sees instructions with o_Instr_Addr 0x0, 0x4, 0x8 in order, each 1 cycle after its response.
- Core ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 requests accepted; o_Mem_Req_Valid low thereafter. Raising ready pops 0x0 and immediately re-enables a request for 0x8.
- Two requests outstanding (0x10, 0x14), redirect to 0x103 -> both responses dropped; next delivered instruction has o_Instr_Addr 0x100 and the data returned for address 0x100.
- Redirect in the same cycle as a response for 0x20 with 2 outstanding -> discard = 1; the second old response is dropped; FIFO empty; next request is to the redirect address.
- Memory ready toggling 1/0 every cycle, random response delays -> instruction stream addresses strictly +4, no loss/duplication over 100 instructions; fifo_count never exceeds 2.
- Fetch PC 0xFFFF_FFFC, request accepted -> next o_Mem_Req_Addr = 0x0000_0000 (wrap).
